// File: rtl/debug_dump_ctrl_if.sv
// Byte stream carrying the register dump frames.
// The master drives valid/data, and the slave drives ready.
interface debug_dump_ctrl_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );
endinterface

// File: rtl/debug_dump_ctrl.sv
// Debug-host dump controller: on a processor wait stall, streams a framed
// r0..rN/ip dump, then holds the core until a continue request releases it.
module debug_dump_ctrl #(
  parameter int WORD_SIZE = 18,
  parameter int REG_COUNT = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wait_for_continue,
  output logic                 wait_continue_execution,
  output logic                 debug_get_param,
  output logic [3:0]           debug_reg_addr,
  input  logic [WORD_SIZE-1:0] debug_data_out,
  input  logic                 cont_req,
  debug_dump_ctrl_if.master    tx,
  output logic                 busy,
  output logic [7:0]           frame_seq
);

  typedef enum logic [3:0] {
    IDLE, HDR, SEQ, CAP, B0, B1, B2, HOLD, RESUME, REARM
  } state_e;

  localparam logic [3:0] LAST_ADDR = 4'(REG_COUNT);

  state_e      state_q;
  logic        wce_q;
  logic        dgp_q;
  logic [3:0]  addr_q;
  logic        txv_q;
  logic [7:0]  txd_q;
  logic        busy_q;
  logic [7:0]  seq_q;
  logic [15:0] hi_q;
  logic        xfer;

  assign xfer = txv_q && tx.tx_ready;

  assign wait_continue_execution = wce_q;
  assign debug_get_param         = dgp_q;
  assign debug_reg_addr          = addr_q;
  assign tx.tx_valid             = txv_q;
  assign tx.tx_data              = txd_q;
  assign busy                    = busy_q;
  assign frame_seq               = seq_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wce_q   <= 1'b0;
      dgp_q   <= 1'b0;
      addr_q  <= 4'd0;
      txv_q   <= 1'b0;
      txd_q   <= 8'h00;
      busy_q  <= 1'b0;
      seq_q   <= 8'h00;
      hi_q    <= 16'h0000;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (wait_for_continue) begin
            state_q <= HDR;
            dgp_q   <= 1'b1;
            addr_q  <= 4'd0;
            busy_q  <= 1'b1;
            txv_q   <= 1'b1;
            txd_q   <= 8'hA5;
          end
        end
        HDR: begin
          if (xfer) begin
            state_q <= SEQ;
            txd_q   <= seq_q;
          end
        end
        SEQ: begin
          if (xfer) begin
            state_q <= CAP;
            txv_q   <= 1'b0;
          end
        end
        CAP: begin
          // upper bytes kept zero-extended so the third byte carries the pad
          state_q <= B0;
          hi_q    <= 16'(debug_data_out >> 8);
          txd_q   <= debug_data_out[7:0];
          txv_q   <= 1'b1;
        end
        B0: begin
          if (xfer) begin
            state_q <= B1;
            txd_q   <= hi_q[7:0];
          end
        end
        B1: begin
          if (xfer) begin
            state_q <= B2;
            txd_q   <= hi_q[15:8];
          end
        end
        B2: begin
          if (xfer) begin
            txv_q <= 1'b0;
            if (addr_q == LAST_ADDR) begin
              state_q <= HOLD;
              dgp_q   <= 1'b0;
              seq_q   <= seq_q + 8'd1;
            end else begin
              state_q <= CAP;
              addr_q  <= addr_q + 4'd1;
            end
          end
        end
        HOLD: begin
          if (!wait_for_continue) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cont_req) begin
            state_q <= RESUME;
            wce_q   <= 1'b1;
          end
        end
        RESUME: begin
          state_q <= REARM;
          wce_q   <= 1'b0;
        end
        REARM: begin
          // wait out the stall just serviced so it is not dumped twice
          if (!wait_for_continue) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_dump_ctrl.sv
// Bench for debug_dump_ctrl: expected frame bytes are queued when a stall
// is raised and matched against the bytes captured from the stream.
module tb_debug_dump_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wfc = 1'b0;
  logic        wce;
  logic        dgp;
  logic [3:0]  dbg_addr;
  logic [17:0] dbg_data;
  logic        cont_req = 1'b0;
  logic        busy;
  logic [7:0]  frame_seq;

  logic [17:0] regs [9];

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_total = 0;
  int         stab_err = 0;
  logic       hold_v = 1'b0;
  logic [7:0] hold_d = 8'h00;

  debug_dump_ctrl_if dif ();

  debug_dump_ctrl #(
    .WORD_SIZE(18),
    .REG_COUNT(8)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .wait_for_continue      (wfc),
    .wait_continue_execution(wce),
    .debug_get_param        (dgp),
    .debug_reg_addr         (dbg_addr),
    .debug_data_out         (dbg_data),
    .cont_req               (cont_req),
    .tx                     (dif.master),
    .busy                   (busy),
    .frame_seq              (frame_seq)
  );

  always #5 clock = ~clock;

  assign dbg_data = (dbg_addr < 4'd9) ? regs[dbg_addr] : 18'h0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && (!dif.tx_valid || dif.tx_data !== hold_d))
        stab_err++;
      if (dif.tx_valid && dif.tx_ready) begin
        rx_q.push_back(dif.tx_data);
        rx_total++;
      end
      hold_v = dif.tx_valid && !dif.tx_ready;
      hold_d = dif.tx_data;
    end
  end

  task automatic push_frame(input logic [7:0] s);
    exp_q.push_back(8'hA5);
    exp_q.push_back(s);
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(regs[i][7:0]);
      exp_q.push_back(regs[i][15:8]);
      exp_q.push_back({6'b0, regs[i][17:16]});
    end
  endtask

  task automatic wait_bytes(input int n, input int lim, output int cyc);
    cyc = 0;
    while (rx_q.size() < n && cyc < lim) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic release_stall();
    @(negedge clock);
    cont_req = 1'b1;
    @(negedge clock);
    cont_req = 1'b0;
    wfc = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (dif.tx_valid !== 1'b0 || dif.tx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_tx got v=%b d=%h want v=0 d=00",
               dif.tx_valid, dif.tx_data);
    end
    checks++;
    if (busy !== 1'b0 || frame_seq !== 8'h00) begin
      failures++;
      $display("FAIL reset_busy_seq got busy=%b seq=%h want 0/00",
               busy, frame_seq);
    end
    checks++;
    if (wce !== 1'b0 || dgp !== 1'b0 || dbg_addr !== 4'd0) begin
      failures++;
      $display("FAIL reset_dbg got wce=%b dgp=%b addr=%0d want 0/0/0",
               wce, dgp, dbg_addr);
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || dif.tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_quiet got busy=%b v=%b want 0/0",
               busy, dif.tx_valid);
    end
  endtask

  task automatic test_basic();
    int cyc;
    int first;
    int busy_bad;
    int pulses;
    logic [7:0] e;
    logic [7:0] a;
    for (int i = 0; i < 8; i++) regs[i] = 18'(i + 1);
    regs[8] = 18'h3FFFF;
    dif.tx_ready = 1'b1;
    @(negedge clock);
    wfc = 1'b1;
    push_frame(8'h00);
    cyc = 0;
    first = -1;
    busy_bad = 0;
    while (rx_q.size() < 29 && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (rx_q.size() > 0 && first < 0) first = cyc;
      if (busy !== 1'b1) busy_bad++;
    end
    checks++;
    if (first != 2) begin
      failures++;
      $display("FAIL first_byte_latency got %0d want 2", first);
    end
    checks++;
    if (cyc != 39) begin
      failures++;
      $display("FAIL hold_latency got %0d want 39", cyc);
    end
    checks++;
    if (busy_bad != 0) begin
      failures++;
      $display("FAIL busy_during_dump got %0d low cycles want 0", busy_bad);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL basic_len got %0d want %0d", rx_q.size(), exp_q.size());
    end else begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = rx_q.pop_front();
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL basic_byte got %h want %h", a, e);
        end
      end
    end
    rx_q.delete();
    exp_q.delete();
    checks++;
    if (frame_seq !== 8'h01 || dgp !== 1'b0) begin
      failures++;
      $display("FAIL basic_seq got seq=%h dgp=%b want 01/0", frame_seq, dgp);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (wce !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL hold_wait got wce=%b busy=%b want 0/1", wce, busy);
    end
    cont_req = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      cont_req = 1'b0;
      if (wce === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL release_pulse got %0d cycles want 1", pulses);
    end
    wfc = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [7:0] e;
    logic [7:0] a;
    for (int i = 0; i < 9; i++) regs[i] = 18'($urandom);
    stab_err = 0;
    @(negedge clock);
    wfc = 1'b1;
    push_frame(8'h01);
    cyc = 0;
    while (rx_q.size() < 29 && cyc < 1000) begin
      @(negedge clock);
      dif.tx_ready = 1'($urandom_range(0, 1));
      cyc++;
    end
    dif.tx_ready = 1'b1;
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL bp_len got %0d want %0d", rx_q.size(), exp_q.size());
    end else begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = rx_q.pop_front();
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL bp_byte got %h want %h", a, e);
        end
      end
    end
    rx_q.delete();
    exp_q.delete();
    checks++;
    if (stab_err != 0) begin
      failures++;
      $display("FAIL bp_stable got %0d violations want 0", stab_err);
    end
    release_stall();
  endtask

  task automatic test_no_redump();
    int cyc;
    int base;
    logic [7:0] e;
    logic [7:0] a;
    base = rx_total;
    @(negedge clock);
    wfc = 1'b1;
    push_frame(8'h02);
    wait_bytes(29, 200, cyc);
    @(negedge clock);
    cont_req = 1'b1;
    @(negedge clock);
    cont_req = 1'b0;
    repeat (5) @(negedge clock);
    checks++;
    if (rx_total - base != 29 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rearm_hold got bytes=%0d busy=%b want 29/1",
               rx_total - base, busy);
    end
    wfc = 1'b0;
    repeat (3) @(negedge clock);
    wfc = 1'b1;
    push_frame(8'h03);
    wait_bytes(58, 200, cyc);
    repeat (10) @(negedge clock);
    checks++;
    if (rx_total - base != 58) begin
      failures++;
      $display("FAIL two_frames got %0d bytes want 58", rx_total - base);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL redump_len got %0d want %0d", rx_q.size(), exp_q.size());
    end else begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = rx_q.pop_front();
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL redump_byte got %h want %h", a, e);
        end
      end
    end
    rx_q.delete();
    exp_q.delete();
    release_stall();
  endtask

  task automatic test_early_continue();
    int cyc;
    logic [7:0] e;
    logic [7:0] a;
    @(negedge clock);
    cont_req = 1'b1;
    @(negedge clock);
    wfc = 1'b1;
    push_frame(8'h04);
    wait_bytes(29, 200, cyc);
    checks++;
    if (wce !== 1'b0) begin
      failures++;
      $display("FAIL early_premature got wce=%b want 0", wce);
    end
    @(negedge clock);
    checks++;
    if (wce !== 1'b1) begin
      failures++;
      $display("FAIL early_release got wce=%b want 1", wce);
    end
    cont_req = 1'b0;
    @(negedge clock);
    checks++;
    if (wce !== 1'b0) begin
      failures++;
      $display("FAIL early_single got wce=%b want 0", wce);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL early_len got %0d want %0d", rx_q.size(), exp_q.size());
    end else begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = rx_q.pop_front();
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL early_byte got %h want %h", a, e);
        end
      end
    end
    rx_q.delete();
    exp_q.delete();
    wfc = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_abort();
    int cyc;
    int pulses;
    logic [7:0] e;
    logic [7:0] a;
    @(negedge clock);
    wfc = 1'b1;
    push_frame(8'h05);
    repeat (10) @(negedge clock);
    wfc = 1'b0;
    pulses = 0;
    cyc = 0;
    while (rx_q.size() < 29 && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (wce === 1'b1) pulses++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (wce === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL abort_pulse got %0d want 0", pulses);
    end
    checks++;
    if (busy !== 1'b0 || frame_seq !== 8'h06) begin
      failures++;
      $display("FAIL abort_idle got busy=%b seq=%h want 0/06", busy, frame_seq);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL abort_len got %0d want %0d", rx_q.size(), exp_q.size());
    end else begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = rx_q.pop_front();
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL abort_byte got %h want %h", a, e);
        end
      end
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    int cyc;
    logic [7:0] e;
    logic [7:0] a;
    @(negedge clock);
    wfc = 1'b1;
    wait_bytes(12, 200, cyc);
    checks++;
    if (dif.tx_valid !== 1'b1 || dbg_addr !== 4'd3) begin
      failures++;
      $display("FAIL pre_reset got v=%b addr=%0d want 1/3",
               dif.tx_valid, dbg_addr);
    end
    #2;
    reset = 1'b1;
    wfc = 1'b0;
    #1;
    checks++;
    if (dif.tx_valid !== 1'b0 || dgp !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got v=%b dgp=%b busy=%b want 0/0/0",
               dif.tx_valid, dgp, busy);
    end
    checks++;
    if (frame_seq !== 8'h00) begin
      failures++;
      $display("FAIL async_seq got %h want 00", frame_seq);
    end
    @(negedge clock);
    reset = 1'b0;
    rx_q.delete();
    exp_q.delete();
    @(negedge clock);
    wfc = 1'b1;
    push_frame(8'h00);
    wait_bytes(29, 200, cyc);
    repeat (2) @(negedge clock);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL post_reset_len got %0d want %0d",
               rx_q.size(), exp_q.size());
    end else begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = rx_q.pop_front();
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL post_reset_byte got %h want %h", a, e);
        end
      end
    end
    rx_q.delete();
    exp_q.delete();
    release_stall();
  endtask

  task automatic test_seq_wrap();
    int cyc;
    logic [7:0] e;
    logic [7:0] a;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    rx_q.delete();
    exp_q.delete();
    for (int f = 0; f < 257; f++) begin
      regs[f % 9] = 18'($urandom);
      @(negedge clock);
      wfc = 1'b1;
      push_frame(8'(f));
      wait_bytes(29, 200, cyc);
      checks++;
      if (rx_q.size() != 29) begin
        failures++;
        $display("FAIL wrap_len frame %0d got %0d want 29", f, rx_q.size());
      end else begin
        checks++;
        if (rx_q[1] !== 8'(f)) begin
          failures++;
          $display("FAIL wrap_seq frame %0d got %h want %h", f, rx_q[1], 8'(f));
        end
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          a = rx_q.pop_front();
          checks++;
          if (a !== e) begin
            failures++;
            $display("FAIL wrap_byte frame %0d got %h want %h", f, a, e);
          end
        end
      end
      rx_q.delete();
      exp_q.delete();
      release_stall();
    end
    checks++;
    if (frame_seq !== 8'h01) begin
      failures++;
      $display("FAIL wrap_final got %h want 01", frame_seq);
    end
  endtask

  initial begin
    dif.tx_ready = 1'b1;
    for (int i = 0; i < 9; i++) regs[i] = 18'h0;
    test_reset();
    test_basic();
    test_backpressure();
    test_no_redump();
    test_early_continue();
    test_abort();
    test_async_reset();
    test_seq_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
